// File: rtl/cmos_pkg.sv
// cmos_pkg: shared defaults and types for the DVP capture front end.
//   DEF_*        default bus/counter widths and the post-reset frame discard count
//   beat_order_e order in which bus beats are placed into a packed pixel
//   cnt_w()      counter width able to hold values 0..n-1 (never narrower than 1 bit)
package cmos_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_BPP        = 2;
    localparam int DEF_HCNT_W     = 12;
    localparam int DEF_VCNT_W     = 12;
    localparam int DEF_WAIT_FRAME = 10;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } beat_order_e;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cmos_beat_packer.sv
// cmos_beat_packer: gathers BYTES_PER_PIX consecutive bus beats into one pixel word.
//   clk      in   pixel clock, rising edge
//   rst_n    in   async active-low reset
//   href     in   line valid; a low cycle abandons any partial pixel
//   data     in   DATA_W bus beat
//   pix_stb  out  one-cycle strobe, the cycle after the last beat of a pixel was sampled
//   pix_data out  DATA_W*BYTES_PER_PIX packed pixel, loaded with pix_stb and held otherwise
module cmos_beat_packer
    import cmos_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int BYTES_PER_PIX = DEF_BPP,
    parameter bit SWAP          = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              href,
    input  logic [DATA_W-1:0]                 data,
    output logic                              pix_stb,
    output logic [DATA_W*BYTES_PER_PIX-1:0]   pix_data
);

    localparam int PW = DATA_W * BYTES_PER_PIX;
    localparam int BW = cnt_w(BYTES_PER_PIX);
    localparam beat_order_e ORDER = SWAP ? LSB_FIRST : MSB_FIRST;

    logic [BW-1:0] r_beat;
    logic [PW-1:0] r_shift;
    logic [PW-1:0] w_shift;
    logic          w_last;

    assign w_last = href && (r_beat == BW'(BYTES_PER_PIX - 1));

    // MSB_FIRST pushes older beats up; LSB_FIRST enters new beats at the top and
    // pushes older ones down, so the first beat ends in the least significant slot.
    always_comb begin
        w_shift = (ORDER == MSB_FIRST) ? ((r_shift << DATA_W) | PW'(data))
                                       : ((r_shift >> DATA_W) | (PW'(data) << (PW - DATA_W)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat   <= '0;
            r_shift  <= '0;
            pix_stb  <= 1'b0;
            pix_data <= '0;
        end else begin
            pix_stb <= w_last;
            if (href) begin
                r_shift <= w_shift;
                r_beat  <= w_last ? '0 : r_beat + 1'b1;
            end else begin
                r_beat  <= '0;
            end
            if (w_last)
                pix_data <= w_shift;
        end
    end

endmodule

// File: rtl/cmos_capture_crop.sv
// cmos_capture_crop: DVP camera capture with post-reset frame discard, pixel packing and crop window.
//   cam_pclk / rst_n         pixel clock (rising edge) / async active-low reset
//   cam_vsync, cam_href      sensor frame sync and line valid
//   cam_data                 sensor bus beat
//   cfg_x_start, cfg_x_size  kept columns [start, start+size); size 0 keeps the whole line
//   cfg_y_start, cfg_y_size  kept rows    [start, start+size); size 0 keeps the whole frame
//   cmos_frame_vsync         vsync two cycles late, only once capture is enabled
//   cmos_frame_href          href two cycles late, only on kept rows of enabled frames
//   cmos_frame_valid         one-cycle strobe per kept pixel
//   cmos_frame_data          packed pixel, updated only with the strobe
//   last_line_pix            complete pixels counted in the most recently finished line
//   frame_cnt                frames delivered since capture was enabled (wraps)
module cmos_capture_crop
    import cmos_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int BYTES_PER_PIX = DEF_BPP,
    parameter int WAIT_FRAME    = DEF_WAIT_FRAME,
    parameter int HCNT_W        = DEF_HCNT_W,
    parameter int VCNT_W        = DEF_VCNT_W,
    parameter bit SWAP          = 1'b0
) (
    input  logic                            cam_pclk,
    input  logic                            rst_n,
    input  logic                            cam_vsync,
    input  logic                            cam_href,
    input  logic [DATA_W-1:0]               cam_data,
    input  logic [HCNT_W-1:0]               cfg_x_start,
    input  logic [HCNT_W-1:0]               cfg_x_size,
    input  logic [VCNT_W-1:0]               cfg_y_start,
    input  logic [VCNT_W-1:0]               cfg_y_size,
    output logic                            cmos_frame_vsync,
    output logic                            cmos_frame_href,
    output logic                            cmos_frame_valid,
    output logic [DATA_W*BYTES_PER_PIX-1:0] cmos_frame_data,
    output logic [HCNT_W-1:0]               last_line_pix,
    output logic [15:0]                     frame_cnt
);

    localparam int PW = DATA_W * BYTES_PER_PIX;
    localparam int WW = cnt_w(WAIT_FRAME + 1);

    logic              r_vs_d0, r_vs_d1, r_hr_d0, r_hr_d1;
    logic [WW-1:0]     r_wait;
    logic              r_en;
    logic [15:0]       r_frame_cnt;
    logic [HCNT_W-1:0] r_xs, r_xz, r_x, r_last_pix;
    logic [VCNT_W-1:0] r_ys, r_yz, r_y;
    logic              r_row_act;
    logic              r_valid;
    logic [PW-1:0]     r_data;

    logic              w_pos_vs, w_hr_rise, w_hr_fall;
    logic              w_wait_done, w_en_next;
    logic [HCNT_W-1:0] w_xs, w_xz, w_x_inc;
    logic [VCNT_W-1:0] w_ys, w_yz, w_y;
    logic              w_row_ok, w_col_ok, w_keep;
    logic              w_pix_stb;
    logic [PW-1:0]     w_pix_data;

    cmos_beat_packer #(
        .DATA_W        (DATA_W),
        .BYTES_PER_PIX (BYTES_PER_PIX),
        .SWAP          (SWAP)
    ) u_packer (
        .clk      (cam_pclk),
        .rst_n    (rst_n),
        .href     (cam_href),
        .data     (cam_data),
        .pix_stb  (w_pix_stb),
        .pix_data (w_pix_data)
    );

    assign w_pos_vs    = r_vs_d0 & ~r_vs_d1;
    assign w_hr_rise   = cam_href & ~r_hr_d0;
    assign w_hr_fall   = r_hr_d0 & ~cam_href;
    assign w_wait_done = (r_wait == WW'(WAIT_FRAME));
    // Enable takes effect on the very vsync that ends the discard, so that frame
    // is already counted as delivered.
    assign w_en_next   = r_en | (w_pos_vs & w_wait_done);

    // On a frame-start cycle the freshly sampled window and the cleared row count
    // are what any coincident comparison must see.
    assign w_xs = w_pos_vs ? cfg_x_start : r_xs;
    assign w_xz = w_pos_vs ? cfg_x_size  : r_xz;
    assign w_ys = w_pos_vs ? cfg_y_start : r_ys;
    assign w_yz = w_pos_vs ? cfg_y_size  : r_yz;
    assign w_y  = w_pos_vs ? '0          : r_y;

    // One extra bit keeps start+size from wrapping back into the window.
    assign w_row_ok = (w_yz == '0) ||
                      (({1'b0, w_y} >= {1'b0, w_ys}) && ({1'b0, w_y} < ({1'b0, w_ys} + {1'b0, w_yz})));
    assign w_col_ok = (w_xz == '0) ||
                      (({1'b0, r_x} >= {1'b0, w_xs}) && ({1'b0, r_x} < ({1'b0, w_xs} + {1'b0, w_xz})));

    // r_x is the index of the pixel being strobed; w_x_inc is the count including it.
    assign w_x_inc = (w_pix_stb && !(&r_x)) ? r_x + 1'b1 : r_x;
    assign w_keep  = r_en & w_pix_stb & r_row_act & w_col_ok;

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d0 <= 1'b0;
            r_vs_d1 <= 1'b0;
            r_hr_d0 <= 1'b0;
            r_hr_d1 <= 1'b0;
        end else begin
            r_vs_d0 <= cam_vsync;
            r_vs_d1 <= r_vs_d0;
            r_hr_d0 <= cam_href;
            r_hr_d1 <= r_hr_d0;
        end
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait      <= '0;
            r_en        <= 1'b0;
            r_frame_cnt <= '0;
            r_xs        <= '0;
            r_xz        <= '0;
            r_ys        <= '0;
            r_yz        <= '0;
        end else if (w_pos_vs) begin
            r_wait <= w_wait_done ? r_wait : r_wait + 1'b1;
            r_en   <= w_en_next;
            if (w_en_next)
                r_frame_cnt <= r_frame_cnt + 16'd1;
            r_xs <= cfg_x_start;
            r_xz <= cfg_x_size;
            r_ys <= cfg_y_start;
            r_yz <= cfg_y_size;
        end
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_last_pix <= '0;
            r_row_act  <= 1'b0;
        end else begin
            r_x <= cam_href ? w_x_inc : '0;
            if (w_pos_vs)
                r_y <= '0;
            else if (w_hr_fall)
                r_y <= r_y + 1'b1;
            if (w_hr_fall)
                r_last_pix <= w_x_inc;
            if (w_hr_rise)
                r_row_act <= w_row_ok;
        end
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_keep;
            if (w_keep)
                r_data <= w_pix_data;
        end
    end

    assign cmos_frame_vsync = r_en & r_vs_d1;
    assign cmos_frame_href  = r_en & r_hr_d1 & r_row_act;
    assign cmos_frame_valid = r_valid;
    assign cmos_frame_data  = r_data;
    assign last_line_pix    = r_last_pix;
    assign frame_cnt        = r_frame_cnt;

endmodule

// File: tb/tb_cmos_capture_crop.sv
// tb_cmos_capture_crop: directed bench for the DVP capture front end.
module tb_cmos_capture_crop;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [11:0] xs = '0, xz = '0, ys = '0, yz = '0;

    logic        vs0, hr0, v0, vs1, hr1, v1, vs2, hr2, v2;
    logic [15:0] d0o, d1o, fc0, fc1, fc2;
    logic [23:0] d2o;
    logic [11:0] llp0, llp1, llp2;

    int errors = 0;
    int checks = 0;
    int c0 = 0, c1 = 0, c2 = 0, hcnt0 = 0, hbad0 = 0, vcnt0 = 0;
    int tb_row = 0;
    int mode = 0;
    int s1 = 0;
    logic [15:0] q0 [256];
    logic [15:0] q1 [256];
    logic [23:0] q2 [256];

    always #5 clk = ~clk;

    cmos_capture_crop dut0 (
        .cam_pclk(clk), .rst_n(rst_n), .cam_vsync(vsync), .cam_href(href), .cam_data(data),
        .cfg_x_start(xs), .cfg_x_size(xz), .cfg_y_start(ys), .cfg_y_size(yz),
        .cmos_frame_vsync(vs0), .cmos_frame_href(hr0), .cmos_frame_valid(v0),
        .cmos_frame_data(d0o), .last_line_pix(llp0), .frame_cnt(fc0)
    );

    cmos_capture_crop #(.SWAP(1'b1)) dut1 (
        .cam_pclk(clk), .rst_n(rst_n), .cam_vsync(vsync), .cam_href(href), .cam_data(data),
        .cfg_x_start(xs), .cfg_x_size(xz), .cfg_y_start(ys), .cfg_y_size(yz),
        .cmos_frame_vsync(vs1), .cmos_frame_href(hr1), .cmos_frame_valid(v1),
        .cmos_frame_data(d1o), .last_line_pix(llp1), .frame_cnt(fc1)
    );

    cmos_capture_crop #(.BYTES_PER_PIX(3), .WAIT_FRAME(0)) dut2 (
        .cam_pclk(clk), .rst_n(rst_n), .cam_vsync(vsync), .cam_href(href), .cam_data(data),
        .cfg_x_start(xs), .cfg_x_size(xz), .cfg_y_start(ys), .cfg_y_size(yz),
        .cmos_frame_vsync(vs2), .cmos_frame_href(hr2), .cmos_frame_valid(v2),
        .cmos_frame_data(d2o), .last_line_pix(llp2), .frame_cnt(fc2)
    );

    always @(negedge clk) begin
        if (v0) begin q0[c0[7:0]] = d0o; c0++; end
        if (v1) begin q1[c1[7:0]] = d1o; c1++; end
        if (v2) begin q2[c2[7:0]] = d2o; c2++; end
        if (hr0) begin hcnt0++; if (tb_row != 1) hbad0++; end
        if (vs0) vcnt0++;
    end

    function automatic logic [7:0] beat_val(input int m, input int r, input int b);
        if (m == 0) return (b % 2 == 0) ? 8'h12 : 8'h34;
        if (m == 1) return (b % 2 == 0) ? 8'(r) : 8'(b / 2);
        return (b % 3 == 0) ? 8'hAA : (b % 3 == 1) ? 8'hBB : 8'hCC;
    endfunction

    task automatic vs_pulse();
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_line(input int r, input int nb);
        tb_row = r;
        for (int b = 0; b < nb; b++) begin
            href = 1'b1;
            data = beat_val(mode, r, b);
            @(negedge clk);
        end
        href = 1'b0;
        data = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input int rows, input int nb);
        vs_pulse();
        for (int r = 0; r < rows; r++) send_line(r, nb);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", v0); end
        checks++; if (hr0 !== 1'b0) begin errors++; $display("FAIL reset_href: got %b expected 0", hr0); end
        checks++; if (vs0 !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b expected 0", vs0); end
        checks++; if (d0o !== 16'h0) begin errors++; $display("FAIL reset_data: got %h expected 0000", d0o); end
        checks++; if (llp0 !== 12'h0) begin errors++; $display("FAIL reset_last_line_pix: got %0d expected 0", llp0); end
        checks++; if (fc0 !== 16'h0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", fc0); end
        checks++; if ({vs1, hr1, v1, vs2, hr2, v2} !== 6'b0) begin errors++; $display("FAIL reset_other_duts: got %b expected 000000", {vs1, hr1, v1, vs2, hr2, v2}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wait_and_swap();
        int s, vc;
        mode = 0;
        s = c0; s1 = c1; vc = vcnt0;
        repeat (10) send_frame(2, 8);
        checks++; if (c0 - s != 0) begin errors++; $display("FAIL discard_valids: got %0d expected 0", c0 - s); end
        checks++; if (c1 - s1 != 0) begin errors++; $display("FAIL discard_valids_swap: got %0d expected 0", c1 - s1); end
        checks++; if (vcnt0 - vc != 0) begin errors++; $display("FAIL discard_vsync_cycles: got %0d expected 0", vcnt0 - vc); end
        checks++; if (fc0 !== 16'd0) begin errors++; $display("FAIL discard_frame_cnt: got %0d expected 0", fc0); end
        s = c0; s1 = c1; vc = vcnt0;
        send_frame(2, 8);
        checks++; if (c0 - s != 8) begin errors++; $display("FAIL frame11_valids: got %0d expected 8", c0 - s); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (q0[8'(s + i)] !== 16'h1234) begin errors++; $display("FAIL frame11_data[%0d]: got %h expected 1234", i, q0[8'(s + i)]); end
        end
        checks++; if (fc0 !== 16'd1) begin errors++; $display("FAIL frame11_frame_cnt: got %0d expected 1", fc0); end
        checks++; if (vcnt0 - vc != 3) begin errors++; $display("FAIL frame11_vsync_cycles: got %0d expected 3", vcnt0 - vc); end
        checks++; if (llp0 !== 12'd4) begin errors++; $display("FAIL frame11_last_line_pix: got %0d expected 4", llp0); end
        checks++; if (c1 - s1 != 8) begin errors++; $display("FAIL swap_valids: got %0d expected 8", c1 - s1); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (q1[8'(s1 + i)] !== 16'h3412) begin errors++; $display("FAIL swap_data[%0d]: got %h expected 3412", i, q1[8'(s1 + i)]); end
        end
        checks++; if (fc1 !== 16'd1) begin errors++; $display("FAIL swap_frame_cnt: got %0d expected 1", fc1); end
        checks++; if (llp1 !== 12'd4) begin errors++; $display("FAIL swap_last_line_pix: got %0d expected 4", llp1); end
    endtask

    task automatic test_crop();
        int s, hs, hb;
        logic [15:0] exp_b [3];
        mode = 1;
        xs = 12'd1; xz = 12'd2; ys = 12'd1; yz = 12'd1;
        s = c0; hs = hcnt0; hb = hbad0;
        vs_pulse();
        // changed mid-frame: must not affect this frame
        xs = '0; xz = '0; ys = '0; yz = '0;
        for (int r = 0; r < 3; r++) send_line(r, 8);
        repeat (2) @(negedge clk);
        checks++; if (c0 - s != 2) begin errors++; $display("FAIL crop_valids: got %0d expected 2", c0 - s); end
        checks++; if (q0[8'(s)] !== 16'h0101) begin errors++; $display("FAIL crop_pix_1_1: got %h expected 0101", q0[8'(s)]); end
        checks++; if (q0[8'(s + 1)] !== 16'h0102) begin errors++; $display("FAIL crop_pix_2_1: got %h expected 0102", q0[8'(s + 1)]); end
        checks++; if (hcnt0 - hs != 8) begin errors++; $display("FAIL crop_href_cycles: got %0d expected 8", hcnt0 - hs); end
        checks++; if (hbad0 - hb != 0) begin errors++; $display("FAIL crop_href_outside_row1: got %0d expected 0", hbad0 - hb); end
        s = c0;
        send_frame(3, 8);
        checks++; if (c0 - s != 12) begin errors++; $display("FAIL crop_full_next_frame: got %0d expected 12", c0 - s); end
        xs = 12'd3; xz = 12'd5; ys = 12'd2; yz = 12'd0;
        s = c0;
        send_frame(3, 8);
        xs = '0; xz = '0; ys = '0; yz = '0;
        exp_b[0] = 16'h0003; exp_b[1] = 16'h0103; exp_b[2] = 16'h0203;
        checks++; if (c0 - s != 3) begin errors++; $display("FAIL crop_edge_valids: got %0d expected 3", c0 - s); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (q0[8'(s + i)] !== exp_b[i]) begin errors++; $display("FAIL crop_edge_data[%0d]: got %h expected %h", i, q0[8'(s + i)], exp_b[i]); end
        end
    endtask

    task automatic test_odd_beats();
        int s;
        mode = 0;
        vs_pulse();
        s = c0;
        send_line(0, 5);
        checks++; if (c0 - s != 2) begin errors++; $display("FAIL odd_valids: got %0d expected 2", c0 - s); end
        checks++; if (llp0 !== 12'd2) begin errors++; $display("FAIL odd_last_line_pix: got %0d expected 2", llp0); end
        s = c0;
        send_line(1, 6);
        checks++; if (c0 - s != 3) begin errors++; $display("FAIL next_line_valids: got %0d expected 3", c0 - s); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (q0[8'(s + i)] !== 16'h1234) begin errors++; $display("FAIL next_line_data[%0d]: got %h expected 1234", i, q0[8'(s + i)]); end
        end
        checks++; if (llp0 !== 12'd3) begin errors++; $display("FAIL next_line_last_line_pix: got %0d expected 3", llp0); end
        checks++; if (fc0 !== 16'd5) begin errors++; $display("FAIL odd_frame_cnt: got %0d expected 5", fc0); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int s;
        mode = 0;
        vs_pulse();
        for (int b = 0; b < 3; b++) begin
            href = 1'b1;
            data = beat_val(0, 0, b);
            @(negedge clk);
        end
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL midline_valid_before_reset: got %b expected 1", v0); end
        checks++; if (hr0 !== 1'b1) begin errors++; $display("FAIL midline_href_before_reset: got %b expected 1", hr0); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({v0, hr0, vs0} !== 3'b000) begin errors++; $display("FAIL async_reset_strobes: got %b expected 000", {v0, hr0, vs0}); end
        checks++; if (d0o !== 16'h0) begin errors++; $display("FAIL async_reset_data: got %h expected 0000", d0o); end
        checks++; if (llp0 !== 12'd0) begin errors++; $display("FAIL async_reset_last_line_pix: got %0d expected 0", llp0); end
        checks++; if (fc0 !== 16'd0) begin errors++; $display("FAIL async_reset_frame_cnt: got %0d expected 0", fc0); end
        @(negedge clk);
        href = 1'b0;
        data = 8'h00;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        s = c0;
        repeat (10) send_frame(2, 8);
        checks++; if (c0 - s != 0) begin errors++; $display("FAIL post_reset_discard_valids: got %0d expected 0", c0 - s); end
        checks++; if (fc0 !== 16'd0) begin errors++; $display("FAIL post_reset_discard_frame_cnt: got %0d expected 0", fc0); end
        s = c0;
        send_frame(2, 8);
        checks++; if (c0 - s != 8) begin errors++; $display("FAIL post_reset_frame11_valids: got %0d expected 8", c0 - s); end
        checks++; if (fc0 !== 16'd1) begin errors++; $display("FAIL post_reset_frame11_frame_cnt: got %0d expected 1", fc0); end
    endtask

    task automatic test_bpp3();
        int s;
        mode = 2;
        vs_pulse();
        s = c2;
        send_line(0, 9);
        checks++; if (c2 - s != 3) begin errors++; $display("FAIL bpp3_valids: got %0d expected 3", c2 - s); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (q2[8'(s + i)] !== 24'hAABBCC) begin errors++; $display("FAIL bpp3_data[%0d]: got %h expected aabbcc", i, q2[8'(s + i)]); end
        end
        checks++; if (llp2 !== 12'd3) begin errors++; $display("FAIL bpp3_last_line_pix: got %0d expected 3", llp2); end
        s = c2;
        send_line(1, 7);
        repeat (2) @(negedge clk);
        checks++; if (c2 - s != 2) begin errors++; $display("FAIL bpp3_partial_valids: got %0d expected 2", c2 - s); end
        checks++; if (fc2 !== 16'd12) begin errors++; $display("FAIL nowait_frame_cnt: got %0d expected 12", fc2); end
        checks++; if ({vs2, hr2} !== 2'b00) begin errors++; $display("FAIL bpp3_idle_syncs: got %b expected 00", {vs2, hr2}); end
    endtask

    initial begin
        test_reset();
        test_wait_and_swap();
        test_crop();
        test_odd_beats();
        test_reset_mid();
        test_bpp3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
